serial_sub8: RTL and testbench

Bit-serial 8-bit subtractor for the 8088 ALU datapath. It is the inverse companion of the 8-bit ripple adder: it computes R = A − B one bit per clock, LSB first, through a single full-subtractor cell. It produces the borrow and, optionally, 8088-style status flags. The ALU control sequencer uses it through a start/done handshake for SUB/CMP operations where area matters more than latency.

---
 rtl/alu8088_pkg.sv | 37 +++
 rtl/full_subtractor.sv | 19 +
 rtl/serial_sub8.sv | 165 ++++++++++++++++
 tb/tb_serial_sub8.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu8088_pkg.sv
// Shared definitions for the 8088 ALU datapath blocks: width, FSM state, flag bit indices.
// No logic of its own; the flag helper is purely combinational.
// No flow control; consumers decide when to register the helper's result.
package alu8088_pkg;

  localparam int ALU_W = 8;

  // Bit positions inside the 4-bit {OF, SF, ZF, CF} status vector
  localparam int FLG_CF = 0;
  localparam int FLG_ZF = 1;
  localparam int FLG_SF = 2;
  localparam int FLG_OF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  // 8088 subtract status: OF is set when operands differ in sign and the
  // result sign does not follow the minuend.
  function automatic logic [3:0] sub_flags(
    input logic [ALU_W-1:0] r,
    input logic             borrow,
    input logic             a7,
    input logic             b7
  );
    logic [3:0] f;
    f         = 4'b0000;
    f[FLG_CF] = borrow;
    f[FLG_ZF] = (r == '0);
    f[FLG_SF] = r[ALU_W-1];
    f[FLG_OF] = (a7 != b7) && (r[ALU_W-1] != a7);
    return f;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow out.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs continuously.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_axb;

  // Borrow out when b exceeds a, or when a and b tie and a borrow comes in
  assign w_axb = a ^ b;
  assign d     = w_axb ^ bin;
  assign bout  = (~a & b) | (~w_axb & bin);

endmodule

// File: rtl/serial_sub8.sv
// Bit-serial 8-bit subtractor R = A - B, LSB first through one full-subtractor cell.
// Latency: 9 cycles from accepted start to done (8 SHIFT + 1 DONE); SUB_FLAGS_EN adds {OF,SF,ZF,CF}.
// Backpressure: start is only taken while busy=0 (IDLE or DONE); starts during SHIFT are dropped.
module serial_sub8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R,
  output logic             borrow,
  output logic [3:0]       flags
);

  import alu8088_pkg::*;

  // Only the 8-bit datapath exists; anything else is rejected at elaboration
  if (WIDTH != ALU_W) begin : g_width_chk
    $error("serial_sub8: only WIDTH=8 is supported");
  end

  localparam logic [2:0] LAST_BIT = 3'(ALU_W - 1);

  sub_state_t       r_state;
  sub_state_t       w_next;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_r_sh;
  logic             r_bin;
  logic [2:0]       r_cnt;

  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_r_final;

  logic [WIDTH-1:0] r_r;
  logic             r_borrow;

  full_subtractor u_cell (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .bin  (r_bin),
    .d    (w_d),
    .bout (w_bout)
  );

  // Value R_sh will hold after the eighth step; lets outputs load on the edge into DONE
  assign w_r_final = {w_d, r_r_sh[WIDTH-1:1]};

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; DONE accepts a new start so back-to-back ops have no gap
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next   = SHIFT;
          w_accept = 1'b1;
        end
      end
      SHIFT: begin
        if (r_cnt == LAST_BIT) begin
          w_next = DONE;
          w_last = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          w_next   = SHIFT;
          w_accept = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture and one-bit-per-cycle shift through the subtractor cell
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_r_sh <= '0;
      r_bin  <= 1'b0;
      r_cnt  <= 3'd0;
    end else if (w_accept) begin
      r_a_sh <= A;
      r_b_sh <= B;
      r_r_sh <= '0;
      r_bin  <= 1'b0;
      r_cnt  <= 3'd0;
    end else if (r_state == SHIFT) begin
      r_a_sh <= r_a_sh >> 1;
      r_b_sh <= r_b_sh >> 1;
      r_r_sh <= w_r_final;
      r_bin  <= w_bout;
      r_cnt  <= r_cnt + 3'd1;
    end
  end

  // Result and borrow update only on the edge into DONE, then hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_r      <= '0;
      r_borrow <= 1'b0;
    end else if (w_last) begin
      r_r      <= w_r_final;
      r_borrow <= w_bout;
    end
  end

`ifdef SUB_FLAGS_EN
  logic       r_a7;
  logic       r_b7;
  logic [3:0] r_flags;

  // Operand sign bits are gone from the shifters by the end, so keep copies for OF
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a7 <= 1'b0;
      r_b7 <= 1'b0;
    end else if (w_accept) begin
      r_a7 <= A[WIDTH-1];
      r_b7 <= B[WIDTH-1];
    end
  end

  // Status flags computed from the final difference alongside R
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= 4'b0000;
    end else if (w_last) begin
      r_flags <= sub_flags(w_r_final, w_bout, r_a7, r_b7);
    end
  end

  assign flags = r_flags;
`else
  assign flags = 4'b0000;
`endif

  assign busy   = (r_state == SHIFT);
  assign done   = (r_state == DONE);
  assign R      = r_r;
  assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_sub8.sv
// Self-checking bench for serial_sub8: table of subtractions plus hand-written
// sequences for ignored start, mid-operation reset and back-to-back operation.
module tb_serial_sub8;

`ifdef SUB_FLAGS_EN
  localparam bit FLG_ON = 1'b1;
`else
  localparam bit FLG_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       busy;
  logic       done;
  logic [7:0] R;
  logic       borrow;
  logic [3:0] flags;

  serial_sub8 #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .R      (R),
    .borrow (borrow),
    .flags  (flags)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;

  typedef struct {
    logic [7:0] r;
    logic       bo;
    logic [3:0] fl;
    int         due;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       bo;
    logic [3:0] fl;
  } vec_t;

  exp_t q[$];
  vec_t tbl[10];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [3:0] fl_exp(input logic [3:0] f);
    return FLG_ON ? f : 4'h0;
  endfunction

  // Scoreboard side: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      done_cnt++;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done with R=0x%0h, expected no done", R);
      end else begin
        e = q.pop_front();
        chk("R", R, e.r);
        chk("borrow", borrow, e.bo);
        chk("flags", flags, e.fl);
        chk("done_cycle", cyc, e.due);
        chk("busy_in_done", busy, 0);
      end
    end
  end

  // Drive one accepted request; accept edge k means done is seen after edge k+8
  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] r, input logic bo, input logic [3:0] fl);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    q.push_back('{r, bo, fl_exp(fl), cyc + 9});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc && q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d results outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    int d0;
    exp_t e;

    // {A, B, R, borrow, {OF,SF,ZF,CF}}
    tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 4'h0};
    tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 4'h5};
    tbl[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 4'h8};
    tbl[3] = '{8'h42, 8'h42, 8'h00, 1'b0, 4'h2};
    tbl[4] = '{8'h00, 8'h01, 8'hFF, 1'b1, 4'h5};
    tbl[5] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 4'h2};
    tbl[6] = '{8'h00, 8'hFF, 8'h01, 1'b1, 4'h1};
    tbl[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 4'hD};
    tbl[8] = '{8'hA5, 8'h5A, 8'h4B, 1'b0, 4'h8};
    tbl[9] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 4'h4};

    rst = 1'b1;
    start = 1'b0;
    A = 8'h00;
    B = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_R", R, 8'h00);
    chk("rst_borrow", borrow, 0);
    chk("rst_flags", flags, 4'h0);
    rst = 1'b0;

    // Table of single operations, each followed by a hold check on R
    for (int i = 0; i < 10; i++) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].bo, tbl[i].fl);
      drain(20);
      repeat (2) @(negedge clk);
      chk("R_hold", R, tbl[i].r);
      chk("idle_busy", busy, 0);
    end

    // Start pulsed in the third busy cycle must be dropped
    d0 = done_cnt;
    issue(8'h05, 8'h03, 8'h02, 1'b0, 4'h0);
    repeat (2) @(negedge clk);
    chk("busy_at_stray_start", busy, 1);
    A = 8'hFF;
    B = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 8'h00;
    drain(20);
    repeat (12) @(negedge clk);
    chk("stray_done_count", done_cnt - d0, 1);
    chk("stray_R", R, 8'h02);

    // Reset in the 4th SHIFT cycle aborts the operation with no done
    issue(8'h12, 8'h34, 8'hDE, 1'b1, 4'h5);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_R", R, 8'h00);
    chk("abort_borrow", borrow, 0);
    chk("abort_flags", flags, 4'h0);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (12) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    issue(8'h10, 8'h01, 8'h0F, 1'b0, 4'h0);
    drain(20);

    // Start held through DONE: second op accepted there, done exactly 9 cycles later
    @(negedge clk);
    A = 8'h80;
    B = 8'h01;
    start = 1'b1;
    @(posedge clk);
    q.push_back('{8'h7F, 1'b0, fl_exp(4'h8), cyc + 9});
    @(negedge clk);
    A = 8'h00;
    B = 8'h01;
    repeat (9) @(posedge clk);
    e = '{8'hFF, 1'b1, fl_exp(4'h5), cyc + 9};
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    drain(30);
    repeat (12) @(negedge clk);
    chk("b2b_final_R", R, 8'hFF);
    chk("b2b_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected $finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
